input_event_arbiter: RTL and testbench
======================================

INPUT_EVENT_ARBITER -- requirements
Module: input_event_arbiter

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4: number of raw button/switch inputs, legal range 2..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required to accept a level change, legal range >=2.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port raw_in, input, N_INPUTS bits: asynchronous raw inputs.
REQ-006 SHALL have port event_valid, output, 1 bit: an event is offered.
REQ-007 SHALL have port event_ready, input, 1 bit: the consumer accepts the event.
REQ-008 SHALL have port event_id, output, $clog2(N_INPUTS) bits: channel index of the offered event.
REQ-009 SHALL have port event_pressed, output, 1 bit: 1 = rising (press) edge, 0 = falling (release) edge.
REQ-010 SHALL have port stable_out, output, N_INPUTS bits: debounced level per channel.
REQ-011 SHALL have port overrun, output, N_INPUTS bits: sticky per-channel lost-event flags.
REQ-012 SHALL have port overrun_clear, input, 1 bit: clears all overrun bits.

Function
REQ-013 SHALL pass each raw_in bit through a 2-flop synchronizer (both stages reset to 0) before any other use.
REQ-014 SHALL keep one debounce counter per channel, of width $clog2(DEBOUNCE_CYCLES); the counter clears whenever the synchronized bit equals stable_out and increments otherwise.
REQ-015 SHALL toggle stable_out[i] and clear its counter in the cycle where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists; a glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
REQ-016 SHALL, on each accepted edge, set pending[i] and store its edge type in a per-channel type register.
REQ-017 SHALL, when an edge arrives while pending[i] is already set and pending[i] is not being granted that cycle, set overrun[i], overwrite the stored edge type, and keep pending[i] set.
REQ-018 SHALL keep pending[i] set with the new type, without setting overrun, when an edge arrives in the same cycle that pending[i] is granted.
REQ-019 SHALL implement a 2-state FSM, IDLE and OFFER.
REQ-020 In IDLE with any pending bit set, SHALL grant the first pending channel at or after rr_ptr, searching round-robin with wrap from N_INPUTS-1 to 0; SHALL load event_id and event_pressed, clear that pending bit, and enter OFFER.
REQ-021 SHALL assert event_valid exactly while in OFFER and SHALL hold event_id and event_pressed stable until event_valid && event_ready.
REQ-022 On event_valid && event_ready, SHALL set rr_ptr to (event_id+1) mod N_INPUTS and return to IDLE, giving a maximum throughput of one event per 2 cycles.
REQ-023 SHALL clear all overrun bits on overrun_clear; a simultaneous new overrun on a channel takes priority, so that bit ends set.
REQ-024 Latency: a raw edge held steady SHALL appear on stable_out 2+DEBOUNCE_CYCLES cycles later, and on event_valid one cycle after stable_out changes if the FSM is IDLE.

Reset
REQ-025 On reset, SHALL immediately clear synchronizers, counters, stable_out, pending, types, overrun and rr_ptr to 0, and set FSM=IDLE, event_valid=0, event_id=0 and event_pressed=0.
REQ-026 Reset asserted mid-OFFER SHALL drop event_valid asynchronously and discard the event; after reset release, no event is replayed.

Configuration
REQ-027 With macro INPUT_EVENT_RELEASE_EN defined, SHALL generate events for both rising and falling debounced edges.
REQ-028 Without INPUT_EVENT_RELEASE_EN, SHALL generate events only for rising edges; falling edges update stable_out only, and event_pressed SHALL be tied to 1.

Verification (N_INPUTS=4, DEBOUNCE_CYCLES=8, event_ready=1 unless stated)
REQ-029 Drive raw_in[2] 0->1 and hold -> stable_out[2]=1 exactly 10 cycles later; event_valid=1 with event_id=2 and event_pressed=1 on the next cycle, for one cycle.
REQ-030 Pulse raw_in[1] high for 5 cycles -> stable_out stays 0 and event_valid is never asserted.
REQ-031 Press channels 0, 1 and 3 in the same cycle -> grants in order 0, 1, 3, spaced 2 cycles apart; then press channels 0 and 3 together -> grant 0 first (rr_ptr wrapped from 3 to 0).
REQ-032 With event_ready=0, press ch0, release ch0, press ch0 -> the first event is held; overrun[0]=1 after the third edge; release event_ready -> exactly one more ch0 event, with event_pressed=1 (or, without the macro, no overrun because the release was suppressed); overrun_clear -> overrun=0.
REQ-033 Assert reset during OFFER -> event_valid=0 in the same cycle; all outputs 0 after release.
REQ-034 With INPUT_EVENT_RELEASE_EN defined, release ch2 -> event_id=2, event_pressed=0; without the macro -> stable_out[2]=0 and no event.

Source files
------------

// File: rtl/input_event_arbiter.sv
// rtl/input_event_arbiter.sv - debounced multi-input edge detector with round-robin event offer
// Optional macro INPUT_EVENT_RELEASE_EN: also report falling (release) edges as events.
module input_event_arbiter #(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_INPUTS-1:0]         raw_in,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [$clog2(N_INPUTS)-1:0] event_id,
    output logic                        event_pressed,
    output logic [N_INPUTS-1:0]         stable_out,
    output logic [N_INPUTS-1:0]         overrun,
    input  logic                        overrun_clear
);
    localparam int ID_W  = $clog2(N_INPUTS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ID_W:0]    N_WIDE  = (ID_W + 1)'(N_INPUTS);

    typedef enum logic {IDLE, OFFER} state_t;

    logic [N_INPUTS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_INPUTS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [N_INPUTS];
    logic [CNT_W-1:0]    cnt_d [N_INPUTS];
    logic [N_INPUTS-1:0] pending_q, pending_d;
    logic [N_INPUTS-1:0] overrun_q, overrun_d;
    logic [N_INPUTS-1:0] edge_ev, grant_vec;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, event_id_q, event_id_d, grant_idx;
    logic [ID_W:0]       scan_idx;
    logic                found;
    state_t              state_q, state_d;
`ifdef INPUT_EVENT_RELEASE_EN
    logic [N_INPUTS-1:0] type_q, type_d;
    logic                event_pressed_q, event_pressed_d;
`endif

    always_comb begin
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        edge_ev  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
`ifdef INPUT_EVENT_RELEASE_EN
                    edge_ev[i]  = 1'b1;
`else
                    edge_ev[i]  = sync2_q[i];
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // Round-robin scan starting at rr_ptr, wrapping past N_INPUTS-1.
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (scan_idx >= N_WIDE) scan_idx = scan_idx - N_WIDE;
            if (!found && pending_q[scan_idx[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = scan_idx[ID_W-1:0];
            end
        end
        grant_vec = (state_q == IDLE && found) ? (N_INPUTS'(1) << grant_idx) : '0;

        pending_d = (pending_q & ~grant_vec) | edge_ev;
        overrun_d = (overrun_clear ? '0 : overrun_q) | (edge_ev & pending_q & ~grant_vec);
`ifdef INPUT_EVENT_RELEASE_EN
        type_d    = (type_q & ~edge_ev) | (sync2_q & edge_ev);
        event_pressed_d = event_pressed_q;
`endif

        state_d    = state_q;
        event_id_d = event_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: if (found) begin
                state_d    = OFFER;
                event_id_d = grant_idx;
`ifdef INPUT_EVENT_RELEASE_EN
                event_pressed_d = type_q[grant_idx];
`endif
            end
            OFFER: if (event_ready) begin
                state_d  = IDLE;
                rr_ptr_d = (event_id_q == ID_W'(N_INPUTS - 1)) ? '0 : event_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            rr_ptr_q   <= '0;
            event_id_q <= '0;
            state_q    <= IDLE;
            for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
`ifdef INPUT_EVENT_RELEASE_EN
            type_q          <= '0;
            event_pressed_q <= 1'b0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rr_ptr_q   <= rr_ptr_d;
            event_id_q <= event_id_d;
            state_q    <= state_d;
            for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= cnt_d[i];
`ifdef INPUT_EVENT_RELEASE_EN
            type_q          <= type_d;
            event_pressed_q <= event_pressed_d;
`endif
        end
    end

    assign event_valid = (state_q == OFFER);
    assign event_id    = event_id_q;
    assign stable_out  = stable_q;
    assign overrun     = overrun_q;
`ifdef INPUT_EVENT_RELEASE_EN
    assign event_pressed = event_pressed_q;
`else
    assign event_pressed = 1'b1;
`endif

endmodule

// File: tb/tb_input_event_arbiter.sv
// tb/tb_input_event_arbiter.sv - directed bench for input_event_arbiter (N_INPUTS=4, DEBOUNCE_CYCLES=8)
module tb_input_event_arbiter;
`ifdef INPUT_EVENT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_id;
    logic       event_pressed;
    logic [3:0] stable_out;
    logic [3:0] overrun;
    logic       overrun_clear;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen;

    input_event_arbiter #(.N_INPUTS(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_id(event_id), .event_pressed(event_pressed),
        .stable_out(stable_out), .overrun(overrun), .overrun_clear(overrun_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; raw_in = 4'b0000; event_ready = 1'b1; overrun_clear = 1'b0;
        repeat (3) tick();
        check("rst_valid",   event_valid, 0);
        check("rst_id",      event_id, 0);
        check("rst_pressed", event_pressed, REL ? 0 : 1);
        check("rst_stable",  stable_out, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick();

        // single press on ch2: 10-cycle debounce latency, event one cycle later
        raw_in = 4'b0100;
        repeat (9) tick();
        check("lat_stable_early", stable_out, 4'b0000);
        tick();
        check("lat_stable",       stable_out, 4'b0100);
        check("lat_valid_early",  event_valid, 0);
        tick();
        check("lat_valid",   event_valid, 1);
        check("lat_id",      event_id, 2);
        check("lat_pressed", event_pressed, 1);
        tick();
        check("lat_valid_drop", event_valid, 0);

        // 5-cycle glitch on ch1 must be rejected
        raw_in[1] = 1'b1;
        repeat (5) tick();
        raw_in[1] = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (event_valid) seen = 1'b1;
        end
        check("glitch_no_event", seen, 0);
        check("glitch_stable",   stable_out, 4'b0100);

        // simultaneous presses on 0,1,3 from rr_ptr=0
        raw_in = 4'b0000;
        pulse_reset();
        raw_in = 4'b1011;
        repeat (10) tick();
        check("rr_stable", stable_out, 4'b1011);
        tick();
        check("rr_g0_valid", event_valid, 1);
        check("rr_g0_id",    event_id, 0);
        tick();
        check("rr_gap", event_valid, 0);
        tick();
        check("rr_g1_valid", event_valid, 1);
        check("rr_g1_id",    event_id, 1);
        tick();
        tick();
        check("rr_g3_valid", event_valid, 1);
        check("rr_g3_id",    event_id, 3);
        tick();

        // release 0,3 then press them together: pointer wrapped to 0
        raw_in = 4'b0010;
        repeat (15) tick();
        check("rr_rel_stable", stable_out, 4'b0010);
        raw_in = 4'b1011;
        repeat (11) tick();
        check("wrap_g0_valid", event_valid, 1);
        check("wrap_g0_id",    event_id, 0);
        tick();
        tick();
        check("wrap_g3_valid", event_valid, 1);
        check("wrap_g3_id",    event_id, 3);

        // backpressure: press/release/press on ch0 with event_ready low
        raw_in = 4'b0000;
        pulse_reset();
        event_ready = 1'b0;
        raw_in = 4'b0001;
        repeat (11) tick();
        check("bp_first_valid", event_valid, 1);
        check("bp_first_id",    event_id, 0);
        raw_in = 4'b0000;
        repeat (10) tick();
        check("bp_rel_stable", stable_out, 4'b0000);
        raw_in = 4'b0001;
        repeat (10) tick();
        check("bp_press_stable", stable_out, 4'b0001);
        check("bp_overrun",      overrun, REL ? 4'b0001 : 4'b0000);
        check("bp_hold_valid",   event_valid, 1);
        check("bp_hold_id",      event_id, 0);
        check("bp_hold_pressed", event_pressed, 1);
        event_ready = 1'b1;
        tick();
        check("bp_accept_idle", event_valid, 0);
        tick();
        check("bp_second_valid",   event_valid, 1);
        check("bp_second_id",      event_id, 0);
        check("bp_second_pressed", event_pressed, 1);
        tick();
        seen = 1'b0;
        repeat (6) begin
            if (event_valid) seen = 1'b1;
            tick();
        end
        check("bp_no_third", seen, 0);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("bp_overrun_clear", overrun, 0);

        // reset while offering drops event_valid asynchronously
        event_ready = 1'b0;
        raw_in = 4'b0011;
        repeat (11) tick();
        check("mr_valid_before", event_valid, 1);
        check("mr_id_before",    event_id, 1);
        reset = 1'b1;
        #1;
        check("mr_valid_async", event_valid, 0);
        raw_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mr_stable",  stable_out, 0);
        check("mr_overrun", overrun, 0);
        check("mr_id",      event_id, 0);
        check("mr_pressed", event_pressed, REL ? 0 : 1);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (event_valid) seen = 1'b1;
        end
        check("mr_no_replay", seen, 0);

        // release on ch2: event only with release reporting enabled
        event_ready = 1'b1;
        raw_in = 4'b0100;
        repeat (11) tick();
        check("rel_press_valid", event_valid, 1);
        check("rel_press_id",    event_id, 2);
        tick();
        raw_in = 4'b0000;
        repeat (10) tick();
        check("rel_stable", stable_out, 4'b0000);
        tick();
        check("rel_valid",   event_valid, REL ? 1 : 0);
        check("rel_id",      event_id, 2);
        check("rel_pressed", event_pressed, REL ? 0 : 1);
        tick();
        check("rel_valid_drop", event_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
